// File: rtl/branch_ctrl_if.sv
// Fetch/decode control-transfer bundle between the decode stage (master) and branch_ctrl (slave).
// Carries the D-stage transfer request, the fetch/decode PCs and the branch statistics.
interface branch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic [2:0]       br_type;
    logic             jmp;
    logic             jr;
    logic             equal;
    logic             bgez;
    logic             bgtz;
    logic             blez;
    logic             bltz;
    logic [15:0]      imm16;
    logic [25:0]      instr_index;
    logic [31:0]      rs_val;

    logic [31:0]      pc_f;
    logic [31:0]      pc_d;
    logic [31:0]      pc8_d;
    logic             valid_d;
    logic             taken_d;
    logic             addr_err;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, br_type, jmp, jr, equal, bgez, bgtz, blez, bltz,
               imm16, instr_index, rs_val,
        input  pc_f, pc_d, pc8_d, valid_d, taken_d, addr_err, br_cnt, taken_cnt
    );

    modport slave (
        input  stall, br_type, jmp, jr, equal, bgez, bgtz, blez, bltz,
               imm16, instr_index, rs_val,
        output pc_f, pc_d, pc8_d, valid_d, taken_d, addr_err, br_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// Fetch PC sequencing with a single architectural delay slot: resolves D-stage branches and
// jumps, redirects fetch one cycle later, and keeps saturating branch statistics.
module branch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    branch_ctrl_if.slave bus
);

    logic [31:0]      pc_f_q, pc_f_d;
    logic [31:0]      pc_d_q, pc_d_d;
    logic             valid_d_q, valid_d_d;
    logic             addr_err_q, addr_err_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic             is_br;
    logic             cond;
    logic             taken;
    logic [31:0]      br_target;
    logic [31:0]      jmp_target;
    logic [31:0]      jr_target;
    logic [31:0]      target;
    logic [31:0]      npc;
    logic             count_br;

    // Condition decode; br_type 0 and the reserved encoding 7 are not branches.
    always_comb begin
        is_br = 1'b1;
        cond  = 1'b0;
        case (bus.br_type)
            3'd1:    cond = bus.equal;
            3'd2:    cond = !bus.equal;
            3'd3:    cond = bus.bgez;
            3'd4:    cond = bus.bgtz;
            3'd5:    cond = bus.blez;
            3'd6:    cond = bus.bltz;
            default: is_br = 1'b0;
        endcase
    end

    always_comb begin
        br_target  = pc_d_q + 32'd4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
        jmp_target = {pc_d_q[31:28], bus.instr_index, 2'b00};
        jr_target  = {bus.rs_val[31:2], 2'b00};
        if (bus.jr) begin
            target = jr_target;
        end else if (bus.jmp) begin
            target = jmp_target;
        end else begin
            target = br_target;
        end
        taken    = valid_d_q & (bus.jr | bus.jmp | (is_br & cond));
        npc      = taken ? target : (pc_f_q + 32'd4);
        count_br = valid_d_q & is_br & !bus.jr & !bus.jmp;
    end

    // A stalled cycle freezes everything and drops the addr_err pulse.
    always_comb begin
        pc_f_d      = pc_f_q;
        pc_d_d      = pc_d_q;
        valid_d_d   = valid_d_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        addr_err_d  = 1'b0;
        if (!bus.stall) begin
            pc_f_d     = npc;
            pc_d_d     = pc_f_q;
            valid_d_d  = 1'b1;
            addr_err_d = valid_d_q & bus.jr & (bus.rs_val[1:0] != 2'b00);
            if (count_br) begin
                if (br_cnt_q != {CNT_W{1'b1}}) begin
                    br_cnt_d = br_cnt_q + 1'b1;
                end
                if (cond && taken_cnt_q != {CNT_W{1'b1}}) begin
                    taken_cnt_d = taken_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q      <= RESET_PC;
            pc_d_q      <= 32'd0;
            valid_d_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            pc_f_q      <= pc_f_d;
            pc_d_q      <= pc_d_d;
            valid_d_q   <= valid_d_d;
            addr_err_q  <= addr_err_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign bus.pc_f      = pc_f_q;
    assign bus.pc_d      = pc_d_q;
    assign bus.pc8_d     = pc_d_q + 32'd8;
    assign bus.valid_d   = valid_d_q;
    assign bus.taken_d   = taken;
    assign bus.addr_err  = addr_err_q;
    assign bus.br_cnt    = br_cnt_q;
    assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a default-width instance plus a CNT_W=2 instance sharing
// the same stimulus, so saturation can be observed alongside the normal counters.
module tb_branch_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    branch_ctrl_if #(.CNT_W(16)) bus ();
    branch_ctrl_if #(.CNT_W(2))  bus_s ();

    branch_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    branch_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(2)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    assign bus_s.stall       = bus.stall;
    assign bus_s.br_type     = bus.br_type;
    assign bus_s.jmp         = bus.jmp;
    assign bus_s.jr          = bus.jr;
    assign bus_s.equal       = bus.equal;
    assign bus_s.bgez        = bus.bgez;
    assign bus_s.bgtz        = bus.bgtz;
    assign bus_s.blez        = bus.blez;
    assign bus_s.bltz        = bus.bltz;
    assign bus_s.imm16       = bus.imm16;
    assign bus_s.instr_index = bus.instr_index;
    assign bus_s.rs_val      = bus.rs_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; state is sampled 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.br_type     = 3'd0;
        bus.jmp         = 1'b0;
        bus.jr          = 1'b0;
        bus.equal       = 1'b0;
        bus.bgez        = 1'b0;
        bus.bgtz        = 1'b0;
        bus.blez        = 1'b0;
        bus.bltz        = 1'b0;
        bus.imm16       = 16'd0;
        bus.instr_index = 26'd0;
        bus.rs_val      = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        bus.stall = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.stall = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        bus.jmp = 1'b1;
        #1;
        checks++; if (bus.pc_f !== 32'h0000_3000) begin failures++; $display("[TB] FAIL reset_pc_f got=%h exp=%h", bus.pc_f, 32'h0000_3000); end
        checks++; if (bus.pc_d !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc_d got=%h exp=%h", bus.pc_d, 32'h0); end
        checks++; if (bus.valid_d !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.valid_d); end
        checks++; if (bus.taken_d !== 1'b0) begin failures++; $display("[TB] FAIL reset_taken_invalid got=%b exp=0", bus.taken_d); end
        checks++; if (bus.br_cnt !== 16'd0 || bus.taken_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", bus.br_cnt, bus.taken_cnt); end
        checks++; if (bus.addr_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_addr_err got=%b exp=0", bus.addr_err); end
        checks++; if (bus.pc8_d !== 32'h8) begin failures++; $display("[TB] FAIL reset_pc8 got=%h exp=%h", bus.pc8_d, 32'h8); end
        bus.jmp = 1'b0;
    endtask

    task automatic test_straight_line();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h3004;
        exp_pc[1] = 32'h3008;
        exp_pc[2] = 32'h300C;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc_f !== exp_pc[i]) begin failures++; $display("[TB] FAIL seq_pc_f[%0d] got=%h exp=%h", i, bus.pc_f, exp_pc[i]); end
            checks++; if (bus.valid_d !== 1'b1) begin failures++; $display("[TB] FAIL seq_valid[%0d] got=%b exp=1", i, bus.valid_d); end
        end
        checks++; if (bus.pc8_d !== 32'h3010) begin failures++; $display("[TB] FAIL seq_pc8 got=%h exp=%h", bus.pc8_d, 32'h3010); end
    endtask

    task automatic test_beq_bne();
        do_reset();
        tick();
        tick();
        bus.br_type = 3'd1;
        bus.equal   = 1'b1;
        bus.imm16   = 16'h0003;
        #1;
        checks++; if (bus.taken_d !== 1'b1) begin failures++; $display("[TB] FAIL beq_taken got=%b exp=1", bus.taken_d); end
        tick();
        clear_inputs();
        checks++; if (bus.pc_d !== 32'h3008) begin failures++; $display("[TB] FAIL beq_delay_slot got=%h exp=%h", bus.pc_d, 32'h3008); end
        checks++; if (bus.pc_f !== 32'h3014) begin failures++; $display("[TB] FAIL beq_target got=%h exp=%h", bus.pc_f, 32'h3014); end
        checks++; if (bus.br_cnt !== 16'd1 || bus.taken_cnt !== 16'd1) begin failures++; $display("[TB] FAIL beq_cnt got=%0d/%0d exp=1/1", bus.br_cnt, bus.taken_cnt); end
        tick();
        bus.br_type = 3'd2;
        bus.equal   = 1'b1;
        bus.imm16   = 16'h0010;
        #1;
        checks++; if (bus.taken_d !== 1'b0) begin failures++; $display("[TB] FAIL bne_taken got=%b exp=0", bus.taken_d); end
        tick();
        clear_inputs();
        checks++; if (bus.pc_f !== 32'h301C) begin failures++; $display("[TB] FAIL bne_pc_f got=%h exp=%h", bus.pc_f, 32'h301C); end
        checks++; if (bus.br_cnt !== 16'd2 || bus.taken_cnt !== 16'd1) begin failures++; $display("[TB] FAIL bne_cnt got=%0d/%0d exp=2/1", bus.br_cnt, bus.taken_cnt); end
    endtask

    task automatic test_backward();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        bus.br_type = 3'd6;
        bus.bltz    = 1'b1;
        bus.imm16   = 16'hFFFF;
        #1;
        checks++; if (bus.pc_d !== 32'h3010) begin failures++; $display("[TB] FAIL bltz_pc_d got=%h exp=%h", bus.pc_d, 32'h3010); end
        tick();
        clear_inputs();
        checks++; if (bus.pc_f !== 32'h3010) begin failures++; $display("[TB] FAIL bltz_target got=%h exp=%h", bus.pc_f, 32'h3010); end
        checks++; if (bus.taken_cnt !== 16'd1) begin failures++; $display("[TB] FAIL bltz_cnt got=%0d exp=1", bus.taken_cnt); end
    endtask

    task automatic test_jumps();
        do_reset();
        tick();
        bus.jmp         = 1'b1;
        bus.instr_index = 26'h0000C10;
        bus.br_type     = 3'd1;
        bus.equal       = 1'b1;
        bus.imm16       = 16'h0003;
        tick();
        clear_inputs();
        checks++; if (bus.pc_f !== 32'h3040) begin failures++; $display("[TB] FAIL jmp_target got=%h exp=%h", bus.pc_f, 32'h3040); end
        checks++; if (bus.br_cnt !== 16'd0) begin failures++; $display("[TB] FAIL jmp_no_count got=%0d exp=0", bus.br_cnt); end
        bus.jr          = 1'b1;
        bus.rs_val      = 32'h0000_3101;
        bus.jmp         = 1'b1;
        bus.instr_index = 26'h0000C10;
        tick();
        clear_inputs();
        checks++; if (bus.pc_f !== 32'h3100) begin failures++; $display("[TB] FAIL jr_target got=%h exp=%h", bus.pc_f, 32'h3100); end
        checks++; if (bus.addr_err !== 1'b1) begin failures++; $display("[TB] FAIL jr_addr_err got=%b exp=1", bus.addr_err); end
        tick();
        checks++; if (bus.addr_err !== 1'b0) begin failures++; $display("[TB] FAIL jr_addr_err_clear got=%b exp=0", bus.addr_err); end
        checks++; if (bus.pc_f !== 32'h3104) begin failures++; $display("[TB] FAIL jr_next got=%h exp=%h", bus.pc_f, 32'h3104); end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        bus.br_type = 3'd1;
        bus.equal   = 1'b1;
        bus.imm16   = 16'h0003;
        bus.stall   = 1'b1;
        #1;
        checks++; if (bus.taken_d !== 1'b1) begin failures++; $display("[TB] FAIL stall_taken got=%b exp=1", bus.taken_d); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (bus.pc_f !== 32'h3008 || bus.pc_d !== 32'h3004) begin failures++; $display("[TB] FAIL stall_hold got=%h/%h exp=3008/3004", bus.pc_f, bus.pc_d); end
        checks++; if (bus.br_cnt !== 16'd0) begin failures++; $display("[TB] FAIL stall_cnt got=%0d exp=0", bus.br_cnt); end
        bus.stall = 1'b0;
        tick();
        clear_inputs();
        checks++; if (bus.pc_f !== 32'h3014 || bus.pc_d !== 32'h3008) begin failures++; $display("[TB] FAIL stall_release got=%h/%h exp=3014/3008", bus.pc_f, bus.pc_d); end
        tick();
        checks++; if (bus.br_cnt !== 16'd1 || bus.pc_f !== 32'h3018) begin failures++; $display("[TB] FAIL stall_once got=%0d/%h exp=1/3018", bus.br_cnt, bus.pc_f); end
    endtask

    task automatic test_reset_override();
        do_reset();
        tick();
        tick();
        bus.br_type = 3'd1;
        bus.equal   = 1'b1;
        bus.imm16   = 16'h0003;
        tick();
        bus.stall = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        bus.stall = 1'b0;
        #1;
        checks++; if (bus.pc_f !== 32'h3000 || bus.valid_d !== 1'b0) begin failures++; $display("[TB] FAIL rst_override got=%h/%b exp=3000/0", bus.pc_f, bus.valid_d); end
        checks++; if (bus.br_cnt !== 16'd0 || bus.taken_cnt !== 16'd0 || bus.taken_d !== 1'b0) begin failures++; $display("[TB] FAIL rst_override_cnt got=%0d/%0d/%b exp=0/0/0", bus.br_cnt, bus.taken_cnt, bus.taken_d); end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        tick();
        bus.br_type = 3'd1;
        bus.equal   = 1'b1;
        bus.imm16   = 16'h0000;
        for (int i = 0; i < 5; i++) tick();
        clear_inputs();
        checks++; if (bus_s.br_cnt !== 2'd3 || bus_s.taken_cnt !== 2'd3) begin failures++; $display("[TB] FAIL sat_cnt got=%0d/%0d exp=3/3", bus_s.br_cnt, bus_s.taken_cnt); end
        checks++; if (bus.br_cnt !== 16'd5 || bus.taken_cnt !== 16'd5) begin failures++; $display("[TB] FAIL wide_cnt got=%0d/%0d exp=5/5", bus.br_cnt, bus.taken_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        bus.jr     = 1'b1;
        bus.rs_val = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        checks++; if (bus.pc_f !== 32'hFFFF_FFFC || bus.addr_err !== 1'b0) begin failures++; $display("[TB] FAIL wrap_jr got=%h/%b exp=fffffffc/0", bus.pc_f, bus.addr_err); end
        tick();
        checks++; if (bus.pc_f !== 32'h0) begin failures++; $display("[TB] FAIL wrap_pc_f got=%h exp=%h", bus.pc_f, 32'h0); end
        checks++; if (bus.pc8_d !== 32'h4) begin failures++; $display("[TB] FAIL wrap_pc8 got=%h exp=%h", bus.pc8_d, 32'h4); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_straight_line();
        test_beq_bne();
        test_backward();
        test_jumps();
        test_stall();
        test_reset_override();
        test_saturation();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
